// File: rtl/notgate_cfg_sequencer.sv
// notgate_cfg_sequencer: AXI4-Lite master that writes NUM_REGS words and reads them back.
// Define NOTGATE_SEQ_TIMEOUT_EN to add a per-handshake watchdog and the timeout port.
module notgate_cfg_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [4:0]                      err_cnt,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
`ifdef NOTGATE_SEQ_TIMEOUT_EN
   ,output logic                            timeout
`endif
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

    if (DW != 32 || NUM_REGS < 1 || NUM_REGS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("notgate_cfg_sequencer: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   seed_q;
    logic            aw_done;
    logic            w_done;
    logic            last;
    logic            aw_hs;
    logic            w_hs;
    logic            rd_bad;
    logic [AW-1:0]   addr_cur;
    logic [DW-1:0]   data_cur;

    assign last     = (idx == LAST);
    assign addr_cur = BASE_ADDR + AW'({idx, 2'b00});
    assign data_cur = seed_q + DW'(idx);
    assign aw_hs    = m_axi_awvalid && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign rd_bad   = (m_axi_rresp != 2'b00) || (m_axi_rdata != data_cur);

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = '1;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

`ifdef NOTGATE_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT_CYCLES);
    logic [WDW-1:0] wdog;
    logic           wd_wait;
    logic           abort;
    assign wd_wait = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);
`endif

    // state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_n;
    end

    // next-state selection, including the watchdog abort when enabled
    always_comb begin
        state_n = state;
`ifdef NOTGATE_SEQ_TIMEOUT_EN
        abort = 1'b0;
`endif
        case (state)
            IDLE:    if (start) state_n = WR_REQ;
            WR_REQ:  if (aw_done && w_done) state_n = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_n = last ? RD_REQ : WR_REQ;
            RD_REQ:  if (m_axi_arready) state_n = RD_DATA;
            RD_DATA: if (m_axi_rvalid) state_n = last ? FINISH : RD_REQ;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef NOTGATE_SEQ_TIMEOUT_EN
        if (wd_wait && wdog == WD_LIM && state_n == state) begin
            abort   = 1'b1;
            state_n = FINISH;
        end
`endif
    end

    // AXI channel drive; address and data are only presented while valid
    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_wdata   = '0;
        m_axi_araddr  = '0;
        case (state)
            WR_REQ: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                m_axi_awaddr  = addr_cur;
                m_axi_wdata   = data_cur;
            end
            WR_RESP: m_axi_bready = 1'b1;
            RD_REQ: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = addr_cur;
            end
            RD_DATA: m_axi_rready = 1'b1;
            default: ;
        endcase
    end

    // sequence datapath: index, handshake flags, error count and status
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            seed_q  <= '0;
            idx     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q  <= seed;
                        idx     <= '0;
                        err_cnt <= '0;
                        busy    <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (state_n != WR_REQ) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) err_cnt <= sat_inc(err_cnt);
                        idx <= last ? '0 : idx + 1'b1;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        if (rd_bad) err_cnt <= sat_inc(err_cnt);
                        idx <= last ? '0 : idx + 1'b1;
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_cnt == 5'd0);
                end
                default: ;
            endcase
`ifdef NOTGATE_SEQ_TIMEOUT_EN
            if (abort) err_cnt <= sat_inc(err_cnt);
`endif
        end
    end

`ifdef NOTGATE_SEQ_TIMEOUT_EN
    // watchdog restarts on every state change and saturates at the limit
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                wdog <= '0;
        else if (state_n != state) wdog <= '0;
        else if (wdog != WD_LIM)   wdog <= wdog + 1'b1;
    end

    // sticky abort flag, cleared by the next accepted start
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                      timeout <= 1'b0;
        else if (state == IDLE && start) timeout <= 1'b0;
        else if (abort)                  timeout <= 1'b1;
    end
`endif

endmodule

// File: doc/notgate_cfg_sequencer.md
Name: notgate_cfg_sequencer

Overview:
- AXI4-Lite master that configures and self-checks the notgate register slave (4 x 32-bit registers).
- On a start pulse it writes NUM_REGS incrementing words starting at SEED, then reads every register back and compares.
- Reports busy, done, pass and an error count.
- Sits between local control logic and the slave's S00_AXI port; this is the in-fabric equivalent of the bring-up write/readback sequence.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- NUM_REGS, 4, number of consecutive registers to sequence (1..16).
- BASE_ADDR, 32'h0000_0000, address of register 0.
- TIMEOUT_CYCLES, 1023, watchdog limit per handshake. Used only with the optional feature.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start pulse
- seed  in  32  first write value, sampled on the accepted start
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- pass  out  1  last sequence had err_cnt==0
- err_cnt  out  5  mismatches plus non-OKAY responses, saturating at 31
- m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  write address
- m_axi_awprot  out  3  constant 3'b000
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  constant 4'hF
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  read address
- m_axi_arprot  out  3  constant 3'b000
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready

Behaviour:
- Reset (async, ARESET=1): state=IDLE; all valid/ready outputs 0; busy=0, done=0, pass=0, err_cnt=0; addresses and wdata 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, FINISH.
- IDLE: start=1 -> capture seed, idx=0, clear err_cnt, busy=1, go to WR_REQ. start while busy is ignored.
- WR_REQ:
  - awaddr = BASE_ADDR + 4*idx; wdata = seed + idx (mod 2^32).
  - awvalid and wvalid rise in the same cycle.
  - Each drops the cycle after its own handshake; AW and W may complete in either order or together.
  - Once both have completed -> WR_RESP.
- WR_RESP:
  - bready=1; on bvalid, bresp!=2'b00 increments err_cnt.
  - If idx==NUM_REGS-1 -> idx=0, RD_REQ; else idx+1, WR_REQ.
- RD_REQ: araddr = BASE_ADDR + 4*idx; arvalid=1 until arready -> RD_DATA.
- RD_DATA:
  - rready=1; on rvalid, err_cnt increments once if rresp!=OKAY or rdata != seed+idx (one increment even if both fail).
  - If last idx -> FINISH; else idx+1, RD_REQ.
- FINISH (one cycle): done=1, pass=(err_cnt==0), busy=0 -> IDLE. pass holds until the next accepted start, which clears it.
- Transaction ordering:
  - Exactly one outstanding transaction at a time.
  - Valid signals are never withdrawn before their handshake.
  - Address/data are stable while valid is high.
- Latency: with a zero-wait slave, each write takes 3 cycles and each read 2 cycles. Start to done = 5*NUM_REGS+2 cycles.
- err_cnt saturates at 31.

Optional Feature:
- Macro: NOTGATE_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on entry to each of WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - If it reaches TIMEOUT_CYCLES without the awaited handshake: drop all valid/ready, increment err_cnt, go to FINISH.
  - Extra output port timeout (1 bit) is set at the abort and cleared on the next start.
- Undefined: no counter, no timeout port; the FSM waits indefinitely.

Test Plan:
- seed=32'h1, zero-wait slave -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match; done at cycle 22 after start; pass=1, err_cnt=0.
- Slave with random 0-5 cycle awready/wready skew and bvalid/rvalid delay -> same data; valids held stable until handshake; pass=1.
- Slave returns rdata=32'hDEAD_BEEF for 0x8 only -> err_cnt=1, pass=0.
- Slave returns bresp=2'b10 on every write with correct readback -> err_cnt=4, pass=0.
- seed=32'hFFFF_FFFE -> write data FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001; pass=1. Second start asserted while busy is ignored.
- Assert ARESET during RD_DATA -> all valids/readies 0 immediately, busy=0. With NOTGATE_SEQ_TIMEOUT_EN defined and awready stuck at 0 -> timeout=1 after 1023 cycles, done pulses, err_cnt=1.
